// File: rtl/cpu_pkg.sv
// Shared CPU constants: data width, register count and ALU opcodes.
package cpu_pkg;

  localparam int unsigned CPU_DW   = 8;
  localparam int unsigned CPU_NREG = 16;
  localparam int unsigned SEL_W    = 4;
  localparam int unsigned OP_W     = 3;

  localparam logic [OP_W-1:0] ALU_PASS = 3'b000;
  localparam logic [OP_W-1:0] ALU_TEST = 3'b001;
  localparam logic [OP_W-1:0] ALU_ADD  = 3'b010;
  localparam logic [OP_W-1:0] ALU_SUB  = 3'b011;
  localparam logic [OP_W-1:0] ALU_SHL  = 3'b100;

endpackage

// File: rtl/datapath_if.sv
// Controller-to-datapath strobe/result bus.
interface datapath_if #(
  parameter int unsigned DW = cpu_pkg::CPU_DW
);
  import cpu_pkg::*;

  logic              en_rf;
  logic              r_wf;
  logic [SEL_W-1:0]  sel_rf;
  logic              en_reg;
  logic              en_imm;
  logic [DW-1:0]     imm;
  logic              sel_mux;
  logic              en_alu;
  logic [OP_W-1:0]   sel_alu;
  logic [DW-1:0]     alu_out;
  logic              alu_zero;
  logic              alu_carry;

  modport master (
    output en_rf, r_wf, sel_rf, en_reg, en_imm, imm, sel_mux, en_alu, sel_alu,
    input  alu_out, alu_zero, alu_carry
  );

  modport slave (
    input  en_rf, r_wf, sel_rf, en_reg, en_imm, imm, sel_mux, en_alu, sel_alu,
    output alu_out, alu_zero, alu_carry
  );

endinterface

// File: rtl/dp_alu.sv
// Combinational ALU: PASS/TEST/ADD/SUB/SHL; valid=0 flags reserved opcodes.
module dp_alu
  import cpu_pkg::*;
#(
  parameter int unsigned DW = CPU_DW
) (
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  input  logic [OP_W-1:0] op,
  output logic [DW-1:0]   result,
  output logic            zero,
  output logic            carry,
  output logic            valid
);

  logic [DW:0] wide;

  always_comb begin
    result = '0;
    carry  = 1'b0;
    valid  = 1'b1;
    wide   = '0;
    case (op)
      ALU_PASS, ALU_TEST: result = b;
      ALU_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DW-1:0];
        carry  = wide[DW];
      end
      ALU_SUB: begin
        // Top bit of the extended difference is the borrow.
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[DW-1:0];
        carry  = wide[DW];
      end
      ALU_SHL: result = (a[DW-1:3] != '0) ? '0 : (b << a[2:0]);
      default: valid = 1'b0;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/datapath.sv
// Register file, operand registers and registered ALU result/flags.
// Optional debug read port enabled by DATAPATH_DBG_EN.
module datapath
  import cpu_pkg::*;
#(
  parameter int unsigned DW   = CPU_DW,
  parameter int unsigned NREG = CPU_NREG
) (
  input  logic           clk,
  input  logic           rst,
  datapath_if.slave      bus
`ifdef DATAPATH_DBG_EN
  ,
  input  logic [SEL_W-1:0] dbg_sel,
  output logic [DW-1:0]    dbg_data
`endif
);

  localparam int unsigned IDX_W = $clog2(NREG);

  logic [DW-1:0] rf [NREG];
  logic [DW-1:0] rd_q;
  logic [DW-1:0] imm_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] operand_b;
  logic [DW-1:0] alu_res;
  logic          alu_z;
  logic          alu_c;
  logic          alu_vld;
  logic          carry_op;

  assign operand_b = bus.sel_mux ? rd_q : imm_q;
  assign carry_op  = (bus.sel_alu == ALU_ADD) || (bus.sel_alu == ALU_SUB);

  dp_alu #(.DW(DW)) u_alu (
    .a      (a_q),
    .b      (operand_b),
    .op     (bus.sel_alu),
    .result (alu_res),
    .zero   (alu_z),
    .carry  (alu_c),
    .valid  (alu_vld)
  );

  // Every strobe acts on pre-edge values; reset wins over all of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) rf[IDX_W'(i)] <= '0;
      rd_q          <= '0;
      imm_q         <= '0;
      a_q           <= '0;
      bus.alu_out   <= '0;
      bus.alu_zero  <= 1'b1;
      bus.alu_carry <= 1'b0;
    end else begin
      if (bus.en_rf && bus.r_wf)  rd_q <= rf[IDX_W'(bus.sel_rf)];
      if (bus.en_rf && !bus.r_wf) rf[IDX_W'(bus.sel_rf)] <= bus.alu_out;
      if (bus.en_imm) imm_q <= bus.imm;
      if (bus.en_reg) a_q <= operand_b;
      if (bus.en_alu && alu_vld) begin
        bus.alu_out  <= alu_res;
        bus.alu_zero <= alu_z;
        if (carry_op) bus.alu_carry <= alu_c;
      end
    end
  end

`ifdef DATAPATH_DBG_EN
  assign dbg_data = rf[IDX_W'(dbg_sel)];
`endif

endmodule

// File: tb/tb_datapath.sv
// Directed scoreboard bench for datapath: stimulus queues expectations, a negedge monitor checks them.
module tb_datapath;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  datapath_if #(.DW(8)) dp_if();

`ifdef DATAPATH_DBG_EN
  logic [3:0] dbg_sel;
  logic [7:0] dbg_data;
`endif

  datapath #(.DW(8), .NREG(16)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (dp_if)
`ifdef DATAPATH_DBG_EN
    ,
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
`endif
  );

  typedef struct packed {
    logic       is_dbg;
    logic [7:0] out;
    logic       zero;
    logic       carry;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_pass  = 0;
  int    n_total = 0;

  // Monitor: pops one expectation per presented sample.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_total++;
      if (!e.is_dbg) begin
        if (dp_if.alu_out === e.out && dp_if.alu_zero === e.zero && dp_if.alu_carry === e.carry)
          n_pass++;
        else
          $display("FAIL %s: got out=%h z=%b c=%b, want out=%h z=%b c=%b", nm,
                   dp_if.alu_out, dp_if.alu_zero, dp_if.alu_carry, e.out, e.zero, e.carry);
      end else begin
`ifdef DATAPATH_DBG_EN
        if (dbg_data === e.out) n_pass++;
        else $display("FAIL %s: got dbg_data=%h, want %h", nm, dbg_data, e.out);
`else
        $display("FAIL %s: debug check issued without debug port", nm);
`endif
      end
    end
  end

  task automatic idle();
    rst = 1'b0;
    dp_if.en_rf = 1'b0; dp_if.r_wf = 1'b0; dp_if.sel_rf = '0;
    dp_if.en_reg = 1'b0; dp_if.en_imm = 1'b0; dp_if.imm = '0;
    dp_if.sel_mux = 1'b0; dp_if.en_alu = 1'b0; dp_if.sel_alu = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic expect_o(input string nm, input logic [7:0] o, input logic z, input logic c);
    exp_q.push_back('{is_dbg: 1'b0, out: o, zero: z, carry: c});
    name_q.push_back(nm);
  endtask

  task automatic expect_dbg(input string nm, input logic [7:0] v);
    exp_q.push_back('{is_dbg: 1'b1, out: v, zero: 1'b0, carry: 1'b0});
    name_q.push_back(nm);
  endtask

  task automatic load_imm(input logic [7:0] v);
    dp_if.imm = v; dp_if.en_imm = 1'b1; step();
  endtask

  task automatic load_a(input logic mux);
    dp_if.en_reg = 1'b1; dp_if.sel_mux = mux; step();
  endtask

  task automatic rf_read(input logic [3:0] idx);
    dp_if.en_rf = 1'b1; dp_if.r_wf = 1'b1; dp_if.sel_rf = idx; step();
  endtask

  task automatic rf_write(input logic [3:0] idx);
    dp_if.en_rf = 1'b1; dp_if.r_wf = 1'b0; dp_if.sel_rf = idx; step();
  endtask

  task automatic exec(input logic [2:0] op, input logic mux);
    dp_if.en_alu = 1'b1; dp_if.sel_alu = op; dp_if.sel_mux = mux; step();
  endtask

  initial begin
    int wait_cyc;
    idle();
`ifdef DATAPATH_DBG_EN
    dbg_sel = 4'd4;
`endif
    rst = 1'b1; step();
    expect_o("reset", 8'h00, 1'b1, 1'b0);
    step();

    rf_read(4'd5); exec(ALU_PASS, 1'b1);
    expect_o("read_rf5_zero", 8'h00, 1'b1, 1'b0);

    load_imm(8'h2A); exec(ALU_PASS, 1'b0);
    expect_o("pass_imm_2a", 8'h2A, 1'b0, 1'b0);
    rf_write(4'd3);
    load_imm(8'h00); exec(ALU_PASS, 1'b0);
    expect_o("pass_imm_00", 8'h00, 1'b1, 1'b0);
    rf_read(4'd3); exec(ALU_PASS, 1'b1);
    expect_o("read_rf3", 8'h2A, 1'b0, 1'b0);

    load_imm(8'hF0); exec(ALU_PASS, 1'b0); rf_write(4'd1);
    load_imm(8'h20); exec(ALU_PASS, 1'b0); rf_write(4'd2);
    rf_read(4'd1); load_a(1'b1);
    rf_read(4'd2); exec(ALU_ADD, 1'b1);
    expect_o("add_f0_20", 8'h10, 1'b0, 1'b1);
    load_imm(8'h10); load_a(1'b0); load_imm(8'h20); exec(ALU_SUB, 1'b0);
    expect_o("sub_10_20", 8'hF0, 1'b0, 1'b1);

    load_imm(8'h03); load_a(1'b0); load_imm(8'h11); exec(ALU_SHL, 1'b0);
    expect_o("shl_by_3", 8'h88, 1'b0, 1'b1);
    load_imm(8'h09); load_a(1'b0); load_imm(8'h11); exec(ALU_SHL, 1'b0);
    expect_o("shl_by_9", 8'h00, 1'b1, 1'b1);

    load_imm(8'h05); exec(ALU_PASS, 1'b0);
    load_imm(8'h00); exec(ALU_TEST, 1'b0);
    expect_o("test_zero", 8'h00, 1'b1, 1'b1);
    load_imm(8'h7F); exec(3'b110, 1'b0);
    expect_o("op110_hold", 8'h00, 1'b1, 1'b1);
    exec(3'b101, 1'b0); exec(3'b111, 1'b0);
    expect_o("op101_111_hold", 8'h00, 1'b1, 1'b1);

    load_imm(8'h01); load_a(1'b0); load_imm(8'h02); exec(ALU_ADD, 1'b0);
    expect_o("add_no_carry", 8'h03, 1'b0, 1'b0);
    load_imm(8'h01); exec(ALU_SUB, 1'b0);
    expect_o("sub_equal", 8'h00, 1'b1, 1'b0);
    load_imm(8'hFF); exec(ALU_ADD, 1'b0);
    expect_o("add_wrap_zero", 8'h00, 1'b1, 1'b1);

    // Read and execute together: ALU sees the previous rd_q.
    rf_read(4'd2);
    dp_if.en_rf = 1'b1; dp_if.r_wf = 1'b1; dp_if.sel_rf = 4'd1;
    dp_if.en_alu = 1'b1; dp_if.sel_alu = ALU_PASS; dp_if.sel_mux = 1'b1; step();
    expect_o("read_exec_old_rd", 8'h20, 1'b0, 1'b1);
    exec(ALU_PASS, 1'b1);
    expect_o("read_exec_new_rd", 8'hF0, 1'b0, 1'b1);

    // Write and execute together: rf gets pre-edge alu_out.
    load_imm(8'h33);
    dp_if.en_rf = 1'b1; dp_if.r_wf = 1'b0; dp_if.sel_rf = 4'd6;
    dp_if.en_alu = 1'b1; dp_if.sel_alu = ALU_PASS; dp_if.sel_mux = 1'b0; step();
    expect_o("write_exec_out", 8'h33, 1'b0, 1'b1);
    rf_read(4'd6); exec(ALU_PASS, 1'b1);
    expect_o("write_exec_rf6", 8'hF0, 1'b0, 1'b1);

    // Write to the index being read leaves rd_q unchanged.
    load_imm(8'h44); exec(ALU_PASS, 1'b0);
    rf_write(4'd6); exec(ALU_PASS, 1'b1);
    expect_o("write_keeps_rd", 8'hF0, 1'b0, 1'b1);
    rf_write(4'd4);
`ifdef DATAPATH_DBG_EN
    expect_dbg("dbg_rf4_written", 8'hF0);
`endif
    step(); step(); step();
    expect_o("idle_hold", 8'hF0, 1'b0, 1'b1);

    load_imm(8'h55); load_a(1'b0); load_imm(8'h66);
    dp_if.en_rf = 1'b1; dp_if.r_wf = 1'b0; dp_if.sel_rf = 4'd4;
    dp_if.en_alu = 1'b1; dp_if.sel_alu = ALU_ADD; rst = 1'b1; step();
    expect_o("reset_override", 8'h00, 1'b1, 1'b0);
`ifdef DATAPATH_DBG_EN
    step();
    expect_dbg("dbg_rf4_reset", 8'h00);
`endif
    exec(ALU_PASS, 1'b0);
    expect_o("imm_after_reset", 8'h00, 1'b1, 1'b0);
    load_imm(8'h77); exec(ALU_PASS, 1'b0);
    rf_read(4'd4); exec(ALU_PASS, 1'b1);
    expect_o("rf4_after_reset", 8'h00, 1'b1, 1'b0);
    load_imm(8'h04); exec(ALU_ADD, 1'b0);
    expect_o("a_after_reset", 8'h04, 1'b0, 1'b0);

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() != 0) begin
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      $fatal(1, "scoreboard did not drain");
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/datapath.md
DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL have parameter DW, default 8, data width of registers, ALU and buses.
REQ-002 SHALL have parameter NREG, default 16, register-file depth, addressed by sel_rf.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en_rf  input  1  register-file access strobe.
REQ-006 r_wf  input  1  with en_rf: 1 = read rf[sel_rf], 0 = write rf[sel_rf].
REQ-007 sel_rf  input  4  register-file index.
REQ-008 en_reg  input  1  load operand register A from operand mux.
REQ-009 en_imm  input  1  load immediate register from imm.
REQ-010 imm  input  DW  immediate value from controller.
REQ-011 sel_mux  input  1  operand mux: 1 = read-data register, 0 = immediate register.
REQ-012 en_alu  input  1  ALU execute strobe.
REQ-013 sel_alu  input  3  ALU opcode.
REQ-014 alu_out  output  DW  registered ALU result; also RAM write data.
REQ-015 alu_zero  output  1  registered zero flag of last executed op.
REQ-016 alu_carry  output  1  registered carry/borrow of last add/sub.

Function
REQ-017 Operand bus B SHALL be combinational: sel_mux ? rd_q : imm_q.
REQ-018 en_rf=1, r_wf=1: rd_q <= rf[sel_rf] at next posedge; one-cycle read latency.
REQ-019 en_rf=1, r_wf=0: rf[sel_rf] <= alu_out (value before this edge); rd_q unchanged, even if same index.
REQ-020 en_imm=1: imm_q <= imm; en_reg=1: A <= B (pre-edge B).
REQ-021 en_alu=1 SHALL compute from pre-edge A and B; result in alu_out one edge later.
REQ-022 Ops: 000 PASS = B; 001 TEST = B; 010 ADD = A+B; 011 SUB = A-B; 100 SHL = B << A[2:0], result 0 if A[DW-1:3] != 0.
REQ-023 ADD/SUB SHALL wrap modulo 2^DW; alu_carry = carry-out (ADD) or borrow (SUB); other ops leave alu_carry unchanged.
REQ-024 alu_zero SHALL be (result == 0) for every legal op, updated only when en_alu=1.
REQ-025 Opcodes 101-111 with en_alu=1: alu_out, alu_zero, alu_carry unchanged.
REQ-026 All strobes independent; any combination in one cycle SHALL act concurrently on pre-edge values (e.g. read + execute: ALU uses old rd_q).
REQ-027 No strobe asserted: all state holds.

Reset
REQ-028 rst=1 at posedge: rf[0..NREG-1], rd_q, imm_q, A, alu_out <= 0; alu_zero <= 1; alu_carry <= 0.
REQ-029 rst SHALL override all strobes in the same cycle; mid-operation reset discards partial operand state.

Configuration
REQ-030 Macro DATAPATH_DBG_EN defined: adds input dbg_sel (4) and output dbg_data (DW), dbg_data = rf[dbg_sel] combinational, no side effects.
REQ-031 Macro undefined: those ports and their logic SHALL be absent; function otherwise identical.

Structure
REQ-032 Shared package cpu_pkg SHALL hold ALU opcode constants (ALU_PASS, ALU_TEST, ALU_ADD, ALU_SUB, ALU_SHL), data width and register-count constants.
REQ-033 Combinational ALU SHALL be a sub-module dp_alu (A, B, op -> result, zero, carry, valid); register file and pipeline registers stay in datapath.

Verification
REQ-034 Reset, then en_rf=1,r_wf=1,sel_rf=5 -> rd_q=0; alu_zero=1, alu_out=0.
REQ-035 imm=0x2A,en_imm; sel_mux=0,en_alu,sel_alu=000; en_rf,r_wf=0,sel_rf=3; read rf[3] -> 0x2A, alu_zero=0.
REQ-036 rf[1]=0xF0, rf[2]=0x20: load A from rf[1], B=rf[2], ADD -> alu_out=0x10, alu_carry=1; SUB with A=0x10,B=0x20 -> 0xF0, alu_carry=1.
REQ-037 A=3 from imm, B=0x11, SHL -> 0x88; A=9 -> 0x00, alu_zero=1.
REQ-038 TEST on B=0 -> alu_zero=1; then op 110 -> outputs and flags unchanged.
REQ-039 Write rf[4] and assert rst in same cycle -> rf[4]=0; with DATAPATH_DBG_EN, dbg_sel=4 -> dbg_data=0.
